// File: rtl/spare_logic_pkg.sv
// spare_logic_pkg: snapshot layout, tie-off expectations and FSM states for the spare readback
package spare_logic_pkg;
  localparam int SPARE_W  = 42;
  localparam int XZ_LSB   = 0;
  localparam int XI_LSB   = 27;
  localparam int XIB_LSB  = 31;
  localparam int XNA_LSB  = 32;
  localparam int XNO_LSB  = 34;
  localparam int XMX_LSB  = 36;
  localparam int XFQ_LSB  = 38;
  localparam int XFQN_LSB = 40;
  localparam logic [SPARE_W-1:0] SPARE_EXPECTED = {4'b0, 2'b00, 2'b11, 2'b11, 1'b1, 4'hF, 27'b0};
  // Flop outputs have no defined tie-off, so they are excluded from the compare
  localparam logic [SPARE_W-1:0] SPARE_MASK = {4'b0, {38{1'b1}}};
  typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, DONE} state_t;
endpackage

// File: rtl/spare_shift_out.sv
// spare_shift_out: load-once snapshot streamed MSB first over valid/ready, with a last-bit flag
module spare_shift_out #(
  parameter int W = 42
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         data,
  output logic         valid,
  output logic         last
);
  localparam int IW = $clog2(W);
  logic [W-1:0]  snap_q, snap_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d, data_q, data_d, fire;
  assign fire = valid_q && ready;
  // The snapshot itself never shifts; the index walks down and the output bit is re-registered
  always_comb begin
    snap_d  = load ? din : snap_q;
    idx_d   = load ? IW'(W-1) : (fire && idx_q != '0) ? idx_q - 1'b1 : idx_q;
    valid_d = load ? 1'b1 : (fire && idx_q == '0) ? 1'b0 : valid_q;
    data_d  = load ? din[W-1] : (fire && idx_q != '0) ? snap_q[idx_q - 1'b1] : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= 1'b0;
    end else begin
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign data  = data_q;
  assign valid = valid_q;
  assign last  = valid_q && idx_q == '0;
endmodule

// File: rtl/spare_logic_reader.sv
// spare_logic_reader: captures spare-cell outputs, checks tie-offs, streams the snapshot serially
module spare_logic_reader
  import spare_logic_pkg::*;
#(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [26:0] spare_xz,
  input  logic [3:0]  spare_xi,
  input  logic        spare_xib,
  input  logic [1:0]  spare_xna,
  input  logic [1:0]  spare_xno,
  input  logic [1:0]  spare_xmx,
  input  logic [1:0]  spare_xfq,
  input  logic [1:0]  spare_xfqn,
  output logic        ser_data,
  output logic        ser_valid,
  input  logic        ser_ready,
  output logic        busy,
  output logic        done,
  output logic        mismatch
);
  state_t             state_q, state_d;
  logic               mismatch_q, mismatch_d, busy_q, done_q, load, last;
  logic [SPARE_W-1:0] spare_in;
  always_comb begin
    spare_in                  = '0;
    spare_in[XZ_LSB   +: 27]  = spare_xz;
    spare_in[XI_LSB   +: 4]   = spare_xi;
    spare_in[XIB_LSB]         = spare_xib;
    spare_in[XNA_LSB  +: 2]   = spare_xna;
    spare_in[XNO_LSB  +: 2]   = spare_xno;
    spare_in[XMX_LSB  +: 2]   = spare_xmx;
    spare_in[XFQ_LSB  +: 2]   = spare_xfq;
    spare_in[XFQN_LSB +: 2]   = spare_xfqn;
  end
  always_comb begin
    state_d    = state_q;
    mismatch_d = mismatch_q;
    load       = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d    = CAPTURE;
        mismatch_d = 1'b0;
      end
      CAPTURE: begin
        state_d    = SHIFT;
        load       = 1'b1;
        mismatch_d = CHECK_EN && |((spare_in ^ SPARE_EXPECTED) & SPARE_MASK);
      end
      SHIFT: if (ser_valid && ser_ready && last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      mismatch_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mismatch_q <= mismatch_d;
      busy_q     <= state_d != IDLE;
      done_q     <= state_d == DONE;
    end
  end
  spare_shift_out #(.W(SPARE_W)) u_shift (
    .clk   (clk),
    .rst_n (resetn),
    .load  (load),
    .din   (spare_in),
    .ready (ser_ready),
    .data  (ser_data),
    .valid (ser_valid),
    .last  (last)
  );
  assign busy     = busy_q;
  assign done     = done_q;
  assign mismatch = mismatch_q;
endmodule

// File: tb/tb_spare_logic_reader.sv
// tb_spare_logic_reader: randomized readback runs checked against a transaction-level model
module tb_spare_logic_reader;
  logic        clk = 1'b0, resetn = 1'b0, start = 1'b0, ser_ready = 1'b1;
  logic [26:0] xz;
  logic [3:0]  xi;
  logic        xib;
  logic [1:0]  xna, xno, xmx, xfq, xfqn;
  logic        d1_data, d1_valid, d1_busy, d1_done, d1_mis;
  logic        d0_data, d0_valid, d0_busy, d0_done, d0_mis;
  int          errors = 0, checks = 0;
  int          m_left = 0, nrx = 0, ndone = 0, cyc = 0, s_cyc = 0, d_cyc = 0;
  bit          m_cap = 0, m_done = 0, m_mis = 0, rnd_ready = 0;
  logic [41:0] m_snap = '0, rx = '0;
  localparam logic [41:0] NOMINAL = 42'h0FF8000000;

  spare_logic_reader #(.CHECK_EN(1'b1)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .spare_xz(xz), .spare_xi(xi), .spare_xib(xib), .spare_xna(xna), .spare_xno(xno),
    .spare_xmx(xmx), .spare_xfq(xfq), .spare_xfqn(xfqn),
    .ser_data(d1_data), .ser_valid(d1_valid), .ser_ready(ser_ready),
    .busy(d1_busy), .done(d1_done), .mismatch(d1_mis));

  spare_logic_reader #(.CHECK_EN(1'b0)) dut_nochk (
    .clk(clk), .resetn(resetn), .start(start),
    .spare_xz(xz), .spare_xi(xi), .spare_xib(xib), .spare_xna(xna), .spare_xno(xno),
    .spare_xmx(xmx), .spare_xfq(xfq), .spare_xfqn(xfqn),
    .ser_data(d0_data), .ser_valid(d0_valid), .ser_ready(ser_ready),
    .busy(d0_busy), .done(d0_done), .mismatch(d0_mis));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [41:0] inputs();
    return {xfqn, xfq, xmx, xno, xna, xib, xi, xz};
  endfunction

  task automatic drive(input logic [41:0] v);
    {xfqn, xfq, xmx, xno, xna, xib, xi, xz} = v;
  endtask

  function automatic bit bad_tieoff();
    return xz != 0 || xi != 4'hF || xib != 1'b1 || xna != 2'b11 || xno != 2'b11 || xmx != 2'b00;
  endfunction

  function automatic logic [41:0] rnd42();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[41:0];
  endfunction

  // Model: a start seen while idle captures the inputs one edge later, then 42 bits drain on ready
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_left = 0; m_cap = 0; m_done = 0; m_mis = 0; m_snap = '0;
    end else begin
      bit was_busy;
      was_busy = m_cap || m_left > 0 || m_done;
      if (d1_valid && ser_ready) begin rx = {rx[40:0], d1_data}; nrx++; end
      if (d1_done) begin ndone++; d_cyc = cyc; end
      m_done = 0;
      if (m_left > 0 && ser_ready) begin m_left--; m_done = (m_left == 0); end
      if (m_cap) begin m_snap = inputs(); m_left = 42; m_mis = bad_tieoff(); m_cap = 0; end
      else if (start && !was_busy) begin m_cap = 1; m_mis = 0; s_cyc = cyc; end
      cyc++;
    end
  end

  always @(posedge clk) begin
    #1 ser_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  always @(negedge clk) begin
    chk("busy", d1_busy, m_cap || m_left > 0 || m_done);
    chk("valid", d1_valid, m_left > 0);
    chk("done", d1_done, m_done);
    chk("mismatch", d1_mis, m_mis);
    if (m_left > 0) chk("data", d1_data, m_snap[m_left-1]);
    if (!resetn) chk("rst_data", d1_data, 0);
    chk("nochk_mismatch", d0_mis, 0);
    chk("nochk_valid", d0_valid, m_left > 0);
    if (m_left > 0) chk("nochk_data", d0_data, m_snap[m_left-1]);
  end

  task automatic wait_done();
    for (int i = 0; i < 800 && ndone == 0; i++) @(negedge clk);
    chk("done_timeout", ndone != 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_one(input logic [41:0] v, input bit rr, input bit dbl);
    @(posedge clk);
    #1 drive(v); rnd_ready = rr; nrx = 0; ndone = 0; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (3) @(posedge clk);
    #1 drive(rnd42());
    if (dbl) begin
      repeat (5) @(posedge clk);
      #1 start = 1;
      @(posedge clk);
      #1 start = 0;
    end
    wait_done();
    rnd_ready = 0;
    chk("bit_count", nrx, 42);
    chk("done_count", ndone, 1);
    chk("stream", rx, v);
  endtask

  initial begin
    logic [41:0] v;
    drive(NOMINAL);
    repeat (3) @(posedge clk);
    chk("reset_valid", d1_valid, 0);
    chk("reset_busy", d1_busy, 0);
    chk("reset_data", d1_data, 0);
    #1 resetn = 1;
    run_one(NOMINAL, 0, 0);
    chk("nominal_literal", rx, 42'h0FF8000000);
    chk("nominal_mismatch", d1_mis, 0);
    chk("done_latency", d_cyc - s_cyc, 44);
    v = NOMINAL | 42'h20;
    run_one(v, 0, 0);
    chk("xz5_bit", rx[5], 1);
    repeat (5) @(negedge clk);
    chk("xz5_sticky", d1_mis, 1);
    run_one(NOMINAL | {4'b1010, 38'b0}, 0, 0);
    chk("flop_bits", rx[41:38], 4'b1010);
    chk("flop_mismatch", d1_mis, 0);
    run_one(rnd42(), 1, 0);
    run_one(NOMINAL, 0, 1);
    drive(NOMINAL | 42'h1);
    nrx = 0; ndone = 0;
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int i = 0; i < 300 && nrx < 20; i++) @(negedge clk);
    chk("reach_bit20", nrx >= 20, 1);
    #2 resetn = 0;
    #1 chk("midrst_valid", d1_valid, 0);
    chk("midrst_busy", d1_busy, 0);
    chk("midrst_data", d1_data, 0);
    chk("midrst_mis", d1_mis, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    chk("midrst_nodone", ndone, 0);
    run_one(NOMINAL | 42'h1, 0, 0);
    chk("xz0_mismatch", d1_mis, 1);
    chk("xz0_nochk", d0_mis, 0);
    for (int k = 0; k < 4; k++) begin
      v = NOMINAL ^ (($urandom_range(0, 1) == 1) ? (42'h1 << $urandom_range(0, 41)) : 42'h0);
      run_one(v, $urandom_range(0, 1) == 1, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
